// File: rtl/usb_hid_pkg.sv
// Shared definitions for the USB HID host: device type encodings, LED width, LED scheduler states.
package usb_hid_pkg;

    localparam int unsigned LED_W = 4;

    localparam logic [1:0] USB_TYP_NONE  = 2'd0;
    localparam logic [1:0] USB_TYP_KBD   = 2'd1;
    localparam logic [1:0] USB_TYP_MOUSE = 2'd2;
    localparam logic [1:0] USB_TYP_GAME  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } led_sched_state_t;

endpackage

// File: rtl/usb_hid_led_sched.sv
// Sequences keyboard LED updates to the USB HID core: coalesces requests during an update,
// retries on ack timeout, aborts on device loss, and reports done/error strobes.
module usb_hid_led_sched
    import usb_hid_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned TO_W           = 21,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic             req_stb,
    input  logic [LED_W-1:0] req_leds,
    input  logic [1:0]       usb_typ,
    input  logic             usb_active,
    output logic             update_leds_stb,
    output logic [LED_W-1:0] leds,
    input  logic             ack_update_leds_stb,
    output logic             busy,
    output logic             done_stb,
    output logic             err_stb,
    output logic [LED_W-1:0] acked_leds,
    output logic             acked_valid
);

    localparam int unsigned RC_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RC_W-1:0] RETRY_MAX = RC_W'(MAX_RETRIES);

    led_sched_state_t state;
    logic [TO_W-1:0]  timer;
    logic [RC_W-1:0]  retry_cnt;
    logic             pending;
    logic [LED_W-1:0] pending_leds;
    logic             err_dly;

    logic ok;
    logic ev_done;
    logic ev_err;
    logic timed_out;

    assign ok        = usb_active && (usb_typ == USB_TYP_KBD);
    assign timed_out = (timer == TO_LAST);
    assign busy      = (state != ST_IDLE);

    // Events that produce a done or error strobe on the next cycle.
    always_comb begin
        ev_done = 1'b0;
        ev_err  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_stb) begin
                    if (!ok)
                        ev_err = 1'b1;
                    else if (acked_valid && (req_leds == acked_leds))
                        ev_done = 1'b1;
                end
            end
            default: begin
                // Device loss (which also covers a rejected request while busy) outranks ack/timeout.
                if (!ok)
                    ev_err = 1'b1;
                else if (state == ST_WAIT && ack_update_leds_stb)
                    ev_done = 1'b1;
                else if (state == ST_WAIT && timed_out && retry_cnt >= RETRY_MAX)
                    ev_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state           <= ST_IDLE;
            timer           <= '0;
            retry_cnt       <= '0;
            pending         <= 1'b0;
            pending_leds    <= '0;
            err_dly         <= 1'b0;
            update_leds_stb <= 1'b0;
            leds            <= '0;
            done_stb        <= 1'b0;
            err_stb         <= 1'b0;
            acked_leds      <= '0;
            acked_valid     <= 1'b0;
        end else begin
            update_leds_stb <= 1'b0;

            // An error colliding with a done is pushed out by one cycle.
            if (ev_done) begin
                done_stb <= 1'b1;
                err_stb  <= 1'b0;
                err_dly  <= ev_err | err_dly;
            end else begin
                done_stb <= 1'b0;
                err_stb  <= ev_err | err_dly;
                err_dly  <= 1'b0;
            end

            if (!ok)
                acked_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_stb && ok && !(acked_valid && (req_leds == acked_leds))) begin
                        leds            <= req_leds;
                        retry_cnt       <= '0;
                        update_leds_stb <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!ok) begin
                        pending <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        timer <= '0;
                        state <= ST_WAIT;
                        if (req_stb) begin
                            pending      <= 1'b1;
                            pending_leds <= req_leds;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!ok) begin
                        pending <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (ack_update_leds_stb) begin
                        acked_leds  <= leds;
                        acked_valid <= 1'b1;
                        if (req_stb || pending) begin
                            leds            <= req_stb ? req_leds : pending_leds;
                            pending         <= 1'b0;
                            retry_cnt       <= '0;
                            update_leds_stb <= 1'b1;
                            state           <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        timer <= timer + TO_W'(1);
                        if (req_stb) begin
                            pending      <= 1'b1;
                            pending_leds <= req_leds;
                        end
                        if (timed_out) begin
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt       <= retry_cnt + RC_W'(1);
                                update_leds_stb <= 1'b1;
                                state           <= ST_ISSUE;
                            end else begin
                                pending <= 1'b0;
                                state   <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
